tetris_keypad: RTL and testbench

Debounces the game's raw push-buttons and turns them into clean one-cycle move commands with Tetris-style auto-repeat for held keys. Sits directly downstream of the 1 kHz clock divider and samples its square-wave output as a millisecond time base. Feeds KEY_PRESS pulses to the game-logic FSM, which consumes them in the CLK domain.

---
 rtl/tetris_pkg.sv | 26 ++
 rtl/key_channel.sv | 127 ++++++++++++
 rtl/tetris_keypad.sv | 51 +++++
 tb/tb_tetris_keypad.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris keypad: key indices, repeat FSM states
// and default timing constants in millisecond ticks.
package tetris_pkg;

  localparam int KEY_LEFT  = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_ROT   = 3;

  localparam int              DEF_N_KEYS         = 4;
  localparam int              DEF_DEBOUNCE_TICKS = 20;
  localparam int              DEF_REPEAT_DELAY   = 250;
  localparam int              DEF_REPEAT_RATE    = 50;
  localparam logic [3:0]      DEF_REPEAT_MASK    = 4'b0111;

  typedef enum logic [1:0] {
    KS_IDLE,
    KS_DELAY,
    KS_REPEAT
  } key_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchronizer, tick-based debouncer and auto-repeat FSM
// producing a debounced level and one-cycle press/repeat pulses.
module key_channel
  import tetris_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE    = DEF_REPEAT_RATE,
  parameter bit REPEAT_EN      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tick,
  input  logic i_key_raw,
  output logic o_key_level,
  output logic o_key_press
);

  localparam int DB_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam int RP_W = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE - 1);

  logic            r_sync1, r_sync2;
  logic            r_level;
  logic [DB_W-1:0] r_db_cnt;
  logic            w_db_done, w_rise, w_fall;

  key_state_t      r_state, w_state_next;
  logic [RP_W-1:0] r_rp_cnt, w_rp_cnt_next;
  logic            r_press, w_press_next;

  // The level flips on the tick that completes the disagreement run.
  assign w_db_done = (r_sync2 != r_level) && i_tick && (r_db_cnt == DB_LAST);
  assign w_rise    = w_db_done && !r_level;
  assign w_fall    = w_db_done &&  r_level;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_level  <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= i_key_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_db_cnt <= '0;
      end else if (i_tick) begin
        if (w_db_done) begin
          r_level  <= r_sync2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= KS_IDLE;
      r_rp_cnt <= '0;
      r_press  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_rp_cnt <= w_rp_cnt_next;
      r_press  <= w_press_next;
    end
  end

  // NOTE: every output of this block is defaulted first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next  = r_state;
    w_rp_cnt_next = r_rp_cnt;
    w_press_next  = 1'b0;
    if (w_fall) begin
      // Release wins over a repeat pulse due on the same tick.
      w_state_next  = KS_IDLE;
      w_rp_cnt_next = '0;
    end else begin
      case (r_state)
        KS_IDLE: begin
          if (w_rise) begin
            w_press_next  = 1'b1;
            w_rp_cnt_next = '0;
            w_state_next  = REPEAT_EN ? KS_DELAY : KS_IDLE;
          end
        end
        KS_DELAY: begin
          if (i_tick) begin
            if (r_rp_cnt == DELAY_LAST) begin
              w_press_next  = 1'b1;
              w_rp_cnt_next = '0;
              w_state_next  = KS_REPEAT;
            end else begin
              w_rp_cnt_next = r_rp_cnt + RP_W'(1);
            end
          end
        end
        KS_REPEAT: begin
          if (i_tick) begin
            if (r_rp_cnt == RATE_LAST) begin
              w_press_next  = 1'b1;
              w_rp_cnt_next = '0;
            end else begin
              w_rp_cnt_next = r_rp_cnt + RP_W'(1);
            end
          end
        end
        default: begin
          w_state_next  = KS_IDLE;
          w_rp_cnt_next = '0;
        end
      endcase
    end
  end

  assign o_key_level = r_level;
  assign o_key_press = r_press;

endmodule

// File: rtl/tetris_keypad.sv
// Keypad front end: derives the shared millisecond tick from the 1 kHz
// square wave and runs one debounce/auto-repeat channel per button.
module tetris_keypad
  import tetris_pkg::*;
#(
  parameter int                N_KEYS         = DEF_N_KEYS,
  parameter int                DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int                REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter int                REPEAT_RATE    = DEF_REPEAT_RATE,
  parameter logic [N_KEYS-1:0] REPEAT_MASK    = DEF_REPEAT_MASK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_clk,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press
);

  logic r_tick_q;
  logic w_tick;

  // Resetting to 1 suppresses a false tick when tick_clk is already high
  // at reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_q <= 1'b1;
    end else begin
      r_tick_q <= tick_clk;
    end
  end

  assign w_tick = tick_clk & ~r_tick_q;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_channel #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE),
      .REPEAT_EN      (REPEAT_MASK[g])
    ) u_channel (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_tick      (w_tick),
      .i_key_raw   (key_raw[g]),
      .o_key_level (key_level[g]),
      .o_key_press (key_press[g])
    );
  end

endmodule

// File: tb/tb_tetris_keypad.sv
// Scoreboard bench for tetris_keypad: a tick-level reference model queues
// expected press pulses and levels; an independent monitor compares them.
module tb_tetris_keypad;
  import tetris_pkg::*;

  localparam int         DT   = 4;
  localparam int         RD   = 6;
  localparam int         RR   = 2;
  localparam logic [3:0] MASK = 4'b0111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_clk;
  logic [3:0] key_raw;
  logic [3:0] key_level;
  logic [3:0] key_press;

  always #5 clk = ~clk;

  tetris_keypad #(
    .N_KEYS         (4),
    .DEBOUNCE_TICKS (DT),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .REPEAT_MASK    (MASK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_clk  (tick_clk),
    .key_raw   (key_raw),
    .key_level (key_level),
    .key_press (key_press)
  );

  typedef struct {
    int         tick;
    logic [3:0] vec;
  } press_t;

  press_t     press_q[$];
  logic [3:0] level_q[$];
  int         n_tests  = 0;
  int         n_fail   = 0;
  int         cur_tick = 0;
  int         seen_tick = 0;

  // Reference model state, advanced once per tick interval.
  logic [3:0] m_level;
  int         m_run[4];
  int         m_t0[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at tick %0d: got %0h expected %0h", name, cur_tick, act, exp);
    end
  endtask

  task automatic model_reset();
    m_level = '0;
    for (int i = 0; i < 4; i++) begin
      m_run[i] = 0;
      m_t0[i]  = 0;
    end
  endtask

  // A key's level flips once it has disagreed with raw for DT consecutive
  // ticks; a repeat key then pulses at RD, RD+RR, RD+2RR... ticks after the
  // initial press, while the level stays high.
  task automatic model_step(input logic [3:0] raw, input logic [3:0] glitch);
    int         t;
    int         d;
    logic       prev;
    logic [3:0] vec;
    t   = cur_tick + 1;
    vec = '0;
    for (int i = 0; i < 4; i++) begin
      prev = m_level[i];
      if (glitch[i] && raw[i] != m_level[i]) m_run[i] = 0;
      if (raw[i] == m_level[i]) m_run[i] = 0;
      else m_run[i]++;
      if (m_run[i] == DT) begin
        m_level[i] = raw[i];
        m_run[i]   = 0;
      end
      if (!prev && m_level[i]) begin
        vec[i]  = 1'b1;
        m_t0[i] = t;
      end else if (prev && m_level[i] && MASK[i]) begin
        d = t - m_t0[i];
        if (d >= RD && ((d - RD) % RR) == 0) vec[i] = 1'b1;
      end
    end
    level_q.push_back(m_level);
    if (vec != '0) press_q.push_back('{tick: t, vec: vec});
  endtask

  // One 10-cycle tick interval: raw applied at the start of the low phase,
  // optional one-cycle glitch mid-phase, tick on the rising edge.
  task automatic do_tick(input logic [3:0] raw, input logic [3:0] glitch);
    @(negedge clk);
    key_raw  = raw;
    tick_clk = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      if (j == 2) key_raw = raw ^ glitch;
      if (j == 3) key_raw = raw;
    end
    @(negedge clk);
    model_step(raw, glitch);
    cur_tick++;
    tick_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic hold(input logic [3:0] raw, input int n);
    for (int k = 0; k < n; k++) do_tick(raw, 4'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    tick_clk = 1'b1;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset_level", 32'(key_level), 32'd0);
    check("midreset_press", 32'(key_press), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: pops an expected pulse whenever the DUT presents one, and an
  // expected level once per tick.
  initial begin
    press_t e;
    forever begin
      @(posedge clk);
      #1;
      if (key_press != '0) begin
        if (press_q.size() == 0) begin
          check("press_unexpected", 32'(key_press), 32'd0);
        end else begin
          e = press_q.pop_front();
          check("press_tick", 32'(cur_tick), 32'(e.tick));
          check("press_vec", 32'(key_press), 32'(e.vec));
        end
      end
      if (cur_tick != seen_tick) begin
        seen_tick = cur_tick;
        if (level_q.size() != 0) check("level", 32'(key_level), 32'(level_q.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at tick %0d", cur_tick);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r;
    logic [3:0] g;
    rst_n    = 1'b0;
    tick_clk = 1'b1;
    key_raw  = 4'hF;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_level", 32'(key_level), 32'd0);
    check("reset_press", 32'(key_press), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Keys held through reset: no press until a full debounce.
    hold(4'hF, 6);
    hold(4'h0, 6);

    // Rotate key: single pulse, no repeat.
    hold(4'h8, 20);
    hold(4'h0, 6);

    // Bounce on left key: 3-tick highs, 1-tick lows.
    for (int k = 0; k < 30; k++) do_tick(((k % 4) < 3) ? 4'h1 : 4'h0, 4'h0);
    hold(4'h0, 6);

    // Auto-repeat on left key.
    hold(4'h1, 24);
    hold(4'h0, 6);

    // Right key: level falls on the tick a repeat is due, then re-press.
    hold(4'h2, 10);
    hold(4'h0, 6);
    hold(4'h2, 12);
    hold(4'h0, 6);

    // Simultaneous left and down.
    hold(4'h5, 16);
    hold(4'h0, 6);

    // One-cycle glitch back to agreement restarts the debounce.
    do_tick(4'h4, 4'h0);
    do_tick(4'h4, 4'h0);
    do_tick(4'h4, 4'h4);
    hold(4'h4, 8);
    hold(4'h0, 6);

    // Reset while keys are held and repeating.
    hold(4'hF, 8);
    do_reset();
    hold(4'hF, 8);
    hold(4'h0, 6);

    // Random sticky key activity with occasional glitches.
    r = 4'h0;
    for (int k = 0; k < 200; k++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      end
      g = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      do_tick(r, g);
    end
    hold(4'h0, 8);

    repeat (20) @(negedge clk);
    check("pending_press", 32'(press_q.size()), 32'd0);
    check("pending_level", 32'(level_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
